// File: rtl/usart_pkg.sv
// Shared definitions for the USART frame arbiter: FSM encoding, field
// widths, counter width and default timing constants.
package usart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TRIG = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   localparam int DATA_W           = 24;
   localparam int ADDR_W           = 2;
   localparam int MOD_W            = 6;
   localparam int CNT_W            = 17;
   localparam int DEF_TRIG_HOLD    = 4;
   localparam int DEF_FRAME_CYCLES = 90000;

endpackage

// File: rtl/usart_rr_pick.sv
// Combinational winner selection for the frame arbiter.
// Default: round-robin search starting at ptr.
// With USART_ARB_FIXED_PRI_EN defined: lowest-index valid requester wins and
// ptr is ignored.
module usart_rr_pick
   import usart_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [1:0]       ptr,
   output logic [N_REQ-1:0] grant
);

`ifdef USART_ARB_FIXED_PRI_EN
   // Fixed priority: scan downwards so the lowest valid index is written last.
   always_comb begin
      grant = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (valid[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
         end
      end
   end
`else
   // Round-robin: visit (ptr+i) mod N_REQ in order, take the first valid one.
   always_comb begin
      logic found;
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         for (int j = 0; j < N_REQ; j++) begin
            if (!found && (j == ((int'(ptr) + i) % N_REQ)) && valid[j]) begin
               grant[j] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end
`endif

endmodule

// File: rtl/usart_frame_arbiter.sv
// Frame arbiter in front of a USART frame transmitter. Picks one requester,
// latches its payload/address/mode, raises trig for TRIG_HOLD cycles and then
// holds off for FRAME_CYCLES cycles while the frame goes out.
// Optional macro USART_ARB_FIXED_PRI_EN selects fixed lowest-index priority
// instead of round-robin.
// Handshake: req_valid is a level request; it is sampled only in IDLE, and
// the captured requester gets a one-cycle req_ack pulse on the cycle after
// sampling. A request that stays high after its ack competes again.
module usart_frame_arbiter
   import usart_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int TRIG_HOLD    = DEF_TRIG_HOLD,
   parameter int FRAME_CYCLES = DEF_FRAME_CYCLES
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [N_REQ*MOD_W-1:0]  req_mod,
   output logic [N_REQ-1:0]        req_ack,
   output logic                    trig,
   output logic [DATA_W-1:0]       D,
   output logic [ADDR_W-1:0]       Adress,
   output logic [MOD_W-1:0]        Mod_SEL,
   output logic                    busy,
   output logic [1:0]              grant_id,
   output logic [1:0]              dbg_state
);

   state_e             state, state_nx;
   logic [CNT_W-1:0]   cnt;
   logic [1:0]         ptr;
   logic [N_REQ-1:0]   grant;
   logic               capture;
   logic [1:0]         win_idx;
   logic [DATA_W-1:0]  win_data;
   logic [ADDR_W-1:0]  win_addr;
   logic [MOD_W-1:0]   win_mod;

   usart_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .valid (req_valid),
      .ptr   (ptr),
      .grant (grant)
   );

   assign capture = (state == ST_IDLE) && (|req_valid);

   // Decode the one-hot grant into an index and the winner's fields.
   always_comb begin
      win_idx  = '0;
      win_data = '0;
      win_addr = '0;
      win_mod  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            win_idx  = 2'(i);
            win_data = req_data[i*DATA_W +: DATA_W];
            win_addr = req_addr[i*ADDR_W +: ADDR_W];
            win_mod  = req_mod[i*MOD_W +: MOD_W];
         end
      end
   end

   // State register; the phase counter restarts on every state change.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (state_nx != state) cnt <= '0;
         else                   cnt <= cnt + 1'b1;
      end
   end

   // Next-state logic: IDLE -> TRIG on any request, timed exits otherwise.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (|req_valid)                          state_nx = ST_TRIG;
         ST_TRIG: if (cnt == CNT_W'(TRIG_HOLD - 1))        state_nx = ST_WAIT;
         ST_WAIT: if (cnt == CNT_W'(FRAME_CYCLES - 1))     state_nx = ST_IDLE;
         default:                                          state_nx = ST_IDLE;
      endcase
   end

   // Outputs decoded from the registered state, so trig is glitch-free.
   always_comb begin
      trig      = (state == ST_TRIG);
      busy      = (state != ST_IDLE);
      dbg_state = state;
   end

   // Grant registers: payload and id change only on a capture in IDLE.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         req_ack  <= '0;
         D        <= '0;
         Adress   <= '0;
         Mod_SEL  <= '0;
         grant_id <= '0;
         ptr      <= '0;
      end else begin
         req_ack <= capture ? grant : '0;
         if (capture) begin
            D        <= win_data;
            Adress   <= win_addr;
            Mod_SEL  <= win_mod;
            grant_id <= win_idx;
`ifndef USART_ARB_FIXED_PRI_EN
            ptr      <= (win_idx == 2'(N_REQ - 1)) ? 2'd0 : win_idx + 2'd1;
`endif
         end
      end
   end

endmodule

// File: tb/tb_usart_frame_arbiter.sv
// Self-checking bench for usart_frame_arbiter with TRIG_HOLD=4, FRAME_CYCLES=20.
// Honours USART_ARB_FIXED_PRI_EN for the all-valid scenario.
module tb_usart_frame_arbiter;

   localparam int N          = 4;
   localparam int TH         = 4;
   localparam int FC         = 20;
   localparam int SPACING    = TH + FC + 1;
   localparam int W          = 38;   // {ack[3:0], gid[1:0], D[23:0], addr[1:0], mod[5:0]}

   logic            sys_clk = 1'b0;
   logic            sys_rst = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N*24-1:0] req_data  = '0;
   logic [N*2-1:0]  req_addr  = '0;
   logic [N*6-1:0]  req_mod   = '0;
   logic [N-1:0]    req_ack;
   logic            trig;
   logic [23:0]     D;
   logic [1:0]      Adress;
   logic [5:0]      Mod_SEL;
   logic            busy;
   logic [1:0]      grant_id;
   logic [1:0]      dbg_state;

   int n_cmp = 0;
   int n_bad = 0;

   logic [W-1:0] exp_q[$];
   logic [31:0]  cur_fields = '0;

   // monitor state
   logic prev_trig  = 1'b0;
   int   high_len   = 0;
   bit   chk_len    = 1'b1;
   bit   chk_space  = 1'b0;
   int   last_rise  = -1;
   int   trig_rises = 0;
   int   cyc        = 0;

   usart_frame_arbiter #(.N_REQ(N), .TRIG_HOLD(TH), .FRAME_CYCLES(FC)) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_addr  (req_addr),
      .req_mod   (req_mod),
      .req_ack   (req_ack),
      .trig      (trig),
      .D         (D),
      .Adress    (Adress),
      .Mod_SEL   (Mod_SEL),
      .busy      (busy),
      .grant_id  (grant_id),
      .dbg_state (dbg_state)
   );

   // clock / cycle counter
   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [23:0] d, input logic [1:0] a, input logic [5:0] m);
      req_data[i*24 +: 24] = d;
      req_addr[i*2 +: 2]   = a;
      req_mod[i*6 +: 6]    = m;
   endtask

   function automatic logic [W-1:0] exp_word(input int i, input logic [23:0] d,
                                            input logic [1:0] a, input logic [5:0] m);
      logic [3:0] oh;
      oh = 4'b0001 << i;
      return {oh, 2'(i), d, a, m};
   endfunction

   task automatic wait_idle();
      for (int k = 0; k < 100 && busy; k++) tick(1);
      check_val("idle_timeout", busy, 0);
   endtask

   task automatic do_reset();
      req_valid = '0;
      sys_rst   = 1'b1;
      tick(2);
      sys_rst   = 1'b0;
   endtask

   // scoreboard and trig monitor, sampled on the falling edge
   always @(negedge sys_clk) begin
      logic [W-1:0] e;
      if (req_ack != '0) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_ack", req_ack, 0);
         end else begin
            e = exp_q.pop_front();
            check_val("ack", req_ack, e[37:34]);
            check_val("grant_id", grant_id, e[33:32]);
            check_val("payload", {D, Adress, Mod_SEL}, e[31:0]);
            cur_fields = e[31:0];
         end
      end
      if (busy) check_val("hold", {D, Adress, Mod_SEL}, cur_fields);
      if (trig && !prev_trig) begin
         trig_rises++;
         if (chk_space && last_rise >= 0) check_val("trig_spacing", cyc - last_rise, SPACING);
         last_rise = cyc;
         high_len  = 0;
      end
      if (trig) high_len++;
      if (!trig && prev_trig && chk_len) check_val("trig_len", high_len, TH);
      prev_trig = trig;
   end

   initial begin
      int rises0;

      // reset state
      tick(3);
      check_val("rst_trig", trig, 0);
      check_val("rst_ack", req_ack, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_fields", {D, Adress, Mod_SEL, grant_id}, 0);
      check_val("rst_state", dbg_state, 0);
      sys_rst = 1'b0;
      tick(2);

      // single request, timing of trig and busy
      set_req(0, 24'h123456, 2'd2, 6'h15);
      req_valid = 4'b0001;
      exp_q.push_back(exp_word(0, 24'h123456, 2'd2, 6'h15));
      tick(1);
      req_valid = '0;
      check_val("s1_trig_on", trig, 1);
      check_val("s1_busy_on", busy, 1);
      tick(3);
      check_val("s1_trig_last", trig, 1);
      tick(1);
      check_val("s1_trig_off", trig, 0);
      tick(19);
      check_val("s1_busy_end", busy, 1);
      tick(1);
      check_val("s1_busy_low", busy, 0);
      check_val("s1_D_kept", D, 24'h123456);

      // all four requesters held valid
      do_reset();
      for (int i = 0; i < N; i++)
         set_req(i, 24'hA00000 + 24'(i * 16'h1111), 2'(i), 6'(6'h20 + i));
      for (int f = 0; f < 5; f++) begin
`ifdef USART_ARB_FIXED_PRI_EN
         exp_q.push_back(exp_word(0, 24'hA00000, 2'd0, 6'h20));
`else
         exp_q.push_back(exp_word(f % N, 24'hA00000 + 24'((f % N) * 16'h1111),
                                  2'(f % N), 6'(6'h20 + (f % N))));
`endif
      end
      chk_space = 1'b1;
      last_rise = -1;
      req_valid = 4'b1111;
      for (int k = 0; k < 300 && exp_q.size() != 0; k++) tick(1);
      req_valid = '0;
      check_val("rr_timeout", exp_q.size(), 0);
      wait_idle();
      chk_space = 1'b0;

      // short pulse during WAIT is lost; payload edits during WAIT ignored
      set_req(0, 24'h0BEEF0, 2'd1, 6'h0A);
      req_valid = 4'b0001;
      exp_q.push_back(exp_word(0, 24'h0BEEF0, 2'd1, 6'h0A));
      rises0 = trig_rises;
      tick(1);
      req_valid = '0;
      tick(10);
      check_val("s4_in_wait", dbg_state, 2);
      set_req(0, 24'h777777, 2'd3, 6'h3F);
      set_req(2, 24'h222222, 2'd2, 6'h02);
      req_valid = 4'b0100;
      tick(3);
      req_valid = '0;
      wait_idle();
      tick(5);
      check_val("s4_no_frame", trig_rises - rises0, 1);
      check_val("s6_D_unchanged", D, 24'h0BEEF0);
      req_valid = 4'b0001;
      exp_q.push_back(exp_word(0, 24'h777777, 2'd3, 6'h3F));
      tick(1);
      req_valid = '0;
      check_val("s6_D_new", D, 24'h777777);
      wait_idle();

      // reset on the 2nd TRIG cycle
      set_req(1, 24'h5A5A5A, 2'd1, 6'h11);
      req_valid = 4'b0010;
      exp_q.push_back(exp_word(1, 24'h5A5A5A, 2'd1, 6'h11));
      tick(1);
      req_valid = '0;
      chk_len   = 1'b0;
      tick(1);
      check_val("s5_trig_2nd", trig, 1);
      sys_rst = 1'b1;
      tick(1);
      check_val("s5_trig_rst", trig, 0);
      check_val("s5_busy_rst", busy, 0);
      check_val("s5_ack_rst", req_ack, 0);
      check_val("s5_fields_rst", {D, Adress, Mod_SEL, grant_id}, 0);
      sys_rst = 1'b0;
      tick(1);
      chk_len = 1'b1;
      tick(2);
      check_val("s5_no_reack", busy, 0);
      set_req(3, 24'hC0FFEE, 2'd3, 6'h33);
      req_valid = 4'b1000;
      exp_q.push_back(exp_word(3, 24'hC0FFEE, 2'd3, 6'h33));
      tick(1);
      req_valid = '0;
      check_val("s5_after_trig", trig, 1);
      wait_idle();
      tick(3);

      check_val("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/usart_frame_arbiter.md
USART_FRAME_ARBITER -- requirements
Module: usart_frame_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, range 2..4.
REQ-002 Parameter TRIG_HOLD, default 4: cycles trig is held high per frame, minimum 2.
REQ-003 Parameter FRAME_CYCLES, default 90000: hold-off cycles after trig falls, covering 7 bytes of 2*N-cycle slots plus margin.
REQ-004 sys_clk  in  1  single clock, all logic on the rising edge.
REQ-005 sys_rst  in  1  reset, synchronous and active-high.
REQ-006 req_valid  in  N_REQ  per-requester frame request, level.
REQ-007 req_data  in  N_REQ*24  flattened 24-bit payloads; requester i uses bits [24i+23:24i].
REQ-008 req_addr  in  N_REQ*2  flattened address fields.
REQ-009 req_mod  in  N_REQ*6  flattened mode-select fields.
REQ-010 req_ack  out  N_REQ  one-hot, one-cycle pulse marking the captured request.
REQ-011 trig  out  1  frame trigger to the frame transmitter; the transmitter acts on its rising edge.
REQ-012 D  out  24  latched payload to the transmitter.
REQ-013 Adress  out  2  latched address to the transmitter.
REQ-014 Mod_SEL  out  6  latched mode to the transmitter.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 grant_id  out  2  index of the last granted requester.

Function
REQ-017 FSM states are exactly IDLE, TRIG and WAIT.
- IDLE -> TRIG when any req_valid bit is high.
- TRIG -> WAIT after TRIG_HOLD cycles.
- WAIT -> IDLE after FRAME_CYCLES cycles.
REQ-018 Grant selection, in IDLE with any req_valid high at edge T:
- at T+1, D/Adress/Mod_SEL/grant_id take the winner's fields;
- req_ack[winner]=1 for exactly one cycle;
- trig=1; state=TRIG.
REQ-019 trig shall stay high for exactly TRIG_HOLD cycles, then go low on entry to WAIT.
REQ-020 D/Adress/Mod_SEL shall hold their values from the grant until the next grant; they never change while busy=1.
REQ-021 The WAIT counter shall be 17 bits wide, clear on entry to WAIT, and return to IDLE on the cycle the count equals FRAME_CYCLES-1.
REQ-022 Minimum spacing between trig rising edges is TRIG_HOLD+FRAME_CYCLES+1 cycles.
REQ-023 Requests are sampled only in IDLE; req_valid asserted while busy is held off, not lost, provided it stays asserted.
REQ-024 A request withdrawn before being sampled in IDLE shall produce no ack and no frame.
REQ-025 Round-robin mode:
- search starts at pointer ptr;
- after a grant to index g, ptr=(g+1) mod N_REQ;
- a requester that holds valid continuously is granted within N_REQ frames.
REQ-026 A requester that keeps req_valid high after its ack shall be re-arbitrated as a new request; the block performs no duplicate suppression.

Reset
REQ-027 While sys_rst=1 at an edge, the following shall hold:
- state=IDLE, trig=0, req_ack=0, busy=0;
- D=0, Adress=0, Mod_SEL=0, grant_id=0;
- ptr=0 and counters=0.
REQ-028 Reset asserted mid-TRIG or mid-WAIT shall force trig low on the next edge and discard the frame in progress, with no ack reissued.

Configuration
REQ-029 With macro USART_ARB_FIXED_PRI_EN defined, the lowest-index valid requester always wins and ptr is unused.
REQ-030 Without USART_ARB_FIXED_PRI_EN, round-robin per REQ-025 applies.

Structure
REQ-031 A shared package usart_pkg shall hold the FSM state encodings, field widths (24/2/6) and the default TRIG_HOLD/FRAME_CYCLES constants.
REQ-032 Winner selection shall be one sub-module, usart_rr_pick: inputs valid vector and ptr, output one-hot grant; it is combinational and honours the macro.
REQ-033 The FSM, counters and output registers shall stay in usart_frame_arbiter.

Verification
REQ-034 The bench shall use FRAME_CYCLES=20 and TRIG_HOLD=4 and shall cover these directed scenarios:
- Single request: req_valid=0001, req_data[23:0]=24'h123456, addr=2, mod=6'h15 -> next cycle ack=0001, trig high 4 cycles, D=24'h123456, Adress=2, Mod_SEL=6'h15, busy low 25 cycles after the grant.
- All four requesters held valid (round-robin) -> grant_id sequence 0,1,2,3,0; trig rising edges 25 cycles apart.
- Same stimulus with USART_ARB_FIXED_PRI_EN defined -> grant_id stays 0 every frame.
- req_valid[2] pulsed for 3 cycles during WAIT only -> no ack, no trig.
- sys_rst=1 on the 2nd TRIG cycle -> trig=0 and all outputs zero next edge; a request after reset is served normally.
- Payload change on req_data during WAIT -> D unchanged until the next grant.
